// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared types and helpers for the sequential ALU.
// The opcode enum assigns codes 0000-1100; codes 1101-1111 stay unassigned.
// The package also defines the control FSM states and the registered status flag struct.
// It provides two-complement overflow helpers (add_ovf, sub_ovf) driven by operand and result sign bits.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'b0000,
    OP_SUB = 4'b0001,
    OP_NOT = 4'b0010,
    OP_SHL = 4'b0011,
    OP_SHR = 4'b0100,
    OP_AND = 4'b0101,
    OP_OR  = 4'b0110,
    OP_INC = 4'b0111,
    OP_DEC = 4'b1000,
    OP_MUL = 4'b1001,
    OP_SRA = 4'b1010,
    OP_XOR = 4'b1011,
    OP_CMP = 4'b1100
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_e;

  typedef struct packed {
    logic zero;
    logic carry;
    logic negative;
    logic overflow;
    logic illegal;
  } alu_flags_t;

  // Addition overflows when both operands share a sign the result lacks.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
    return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

  // Subtraction overflows when operand signs differ and the result sign flips from a.
  function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
    return (a_msb != b_msb) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/alu_seq_mul.sv
// alu_seq_mul: iterative shift-add multiplier, one multiplier bit per cycle.
// Only compiled into alu_seq when ALU_SEQ_MUL_EN is defined.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : load operands and begin (WIDTH steps)
//   src_a/src_b: multiplicand / multiplier
//   done       : high during the final step; product is valid in that cycle
//   product    : full 2*WIDTH-bit product after the current step
module alu_seq_mul #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   src_a,
  input  logic [WIDTH-1:0]   src_b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      count_q, count_d;
  logic               busy_q, busy_d;

  // Next-state for the shift-add datapath.
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    count_d  = count_q;
    busy_d   = busy_q;
    if (start) begin
      acc_d    = '0;
      mcand_d  = {{WIDTH{1'b0}}, src_a};
      mplier_d = src_b;
      count_d  = CW'(WIDTH);
      busy_d   = 1'b1;
    end else if (busy_q) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end else begin
        acc_d = acc_q;
      end
      mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
      mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
      count_d  = count_q - CW'(1);
      busy_d   = (count_q != CW'(1));
    end else begin
      busy_d = 1'b0;
    end
  end

  // The last step's sum is handed out combinationally so the top can load it
  // on the same edge the multiplier retires.
  assign done    = busy_q && (count_q == CW'(1));
  assign product = acc_d;

  // Multiplier state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
      busy_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready handshakes and status flags.
// One operation in flight; single-cycle ops have latency 1, MUL latency WIDTH+1.
// Optional feature macro: ALU_SEQ_MUL_EN (iterative multiply for opcode 1001;
// when undefined, 1001 is reported as illegal).
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operation handshake (in_ready only in IDLE)
//   src_1, src_2         : operands
//   alu_control          : opcode (see alu_seq_pkg::alu_op_e)
//   out_valid / out_ready: result handshake
//   result               : registered result
//   zero, carry, negative, overflow, illegal : registered flags
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] src_1,
  input  logic [WIDTH-1:0] src_2,
  input  logic [3:0]       alu_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             negative,
  output logic             overflow,
  output logic             illegal
);
  import alu_seq_pkg::*;

  localparam int SHW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);
  localparam logic [WIDTH-1:0] ONE_V   = WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  alu_flags_t       flags_q, flags_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  alu_op_e          op_s;
  logic             accept_s;
  logic [WIDTH:0]   add_s, sub_s, inc_s, dec_s;
  logic             in_range_s;
  logic [SHW-1:0]   amt_s;
  logic [WIDTH-1:0] alu_res_s;
  alu_flags_t       alu_flags_s;
  logic             carry_v, ovf_v, cmp_v, ill_v;

  assign op_s     = alu_op_e'(alu_control);
  assign accept_s = in_valid && in_ready_q;

  // Extra top bit captures carry-out (add) or borrow (subtract).
  assign add_s = {1'b0, src_1} + {1'b0, src_2};
  assign sub_s = {1'b0, src_1} - {1'b0, src_2};
  assign inc_s = {1'b0, src_1} + {1'b0, ONE_V};
  assign dec_s = {1'b0, src_1} - {1'b0, ONE_V};

  // The whole src_2 decides range, so large amounts with zero low bits still flush.
  assign in_range_s = (src_2 < WIDTH_V);
  assign amt_s      = src_2[SHW-1:0];

  // Single-cycle result and flag computation.
  always_comb begin
    alu_res_s   = '0;
    alu_flags_s = '0;
    carry_v     = 1'b0;
    ovf_v       = 1'b0;
    cmp_v       = 1'b0;
    ill_v       = 1'b0;
    case (op_s)
      OP_ADD: begin
        alu_res_s = add_s[WIDTH-1:0];
        carry_v   = add_s[WIDTH];
        ovf_v     = add_ovf(src_1[WIDTH-1], src_2[WIDTH-1], add_s[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res_s = sub_s[WIDTH-1:0];
        carry_v   = sub_s[WIDTH];
        ovf_v     = sub_ovf(src_1[WIDTH-1], src_2[WIDTH-1], sub_s[WIDTH-1]);
      end
      OP_NOT: alu_res_s = ~src_1;
      OP_SHL: begin
        if (in_range_s) begin
          alu_res_s = src_1 << amt_s;
        end else begin
          alu_res_s = '0;
        end
      end
      OP_SHR: begin
        if (in_range_s) begin
          alu_res_s = src_1 >> amt_s;
        end else begin
          alu_res_s = '0;
        end
      end
      OP_AND: alu_res_s = src_1 & src_2;
      OP_OR:  alu_res_s = src_1 | src_2;
      OP_INC: begin
        alu_res_s = inc_s[WIDTH-1:0];
        carry_v   = inc_s[WIDTH];
        ovf_v     = add_ovf(src_1[WIDTH-1], 1'b0, inc_s[WIDTH-1]);
      end
      OP_DEC: begin
        alu_res_s = dec_s[WIDTH-1:0];
        carry_v   = dec_s[WIDTH];
        ovf_v     = sub_ovf(src_1[WIDTH-1], 1'b0, dec_s[WIDTH-1]);
      end
      OP_SRA: begin
        if (in_range_s) begin
          alu_res_s = $unsigned($signed(src_1) >>> amt_s);
        end else begin
          alu_res_s = {WIDTH{src_1[WIDTH-1]}};
        end
      end
      OP_XOR: alu_res_s = src_1 ^ src_2;
      OP_CMP: begin
        alu_res_s = '0;
        carry_v   = sub_s[WIDTH];
        ovf_v     = sub_ovf(src_1[WIDTH-1], src_2[WIDTH-1], sub_s[WIDTH-1]);
        cmp_v     = 1'b1;
      end
      // MUL is routed through the multiplier by the FSM; here it is illegal.
      default: ill_v = 1'b1;
    endcase

    if (ill_v) begin
      alu_res_s           = '0;
      alu_flags_s.illegal = 1'b1;
    end else begin
      alu_flags_s.carry    = carry_v;
      alu_flags_s.overflow = ovf_v;
      alu_flags_s.negative = alu_res_s[WIDTH-1];
      if (cmp_v) begin
        alu_flags_s.zero = (src_1 == src_2);
      end else begin
        alu_flags_s.zero = (alu_res_s == '0);
      end
    end
  end

`ifdef ALU_SEQ_MUL_EN
  logic               mul_start_s;
  logic               mul_done_s;
  logic [2*WIDTH-1:0] mul_prod_s;

  assign mul_start_s = accept_s && (op_s == OP_MUL);

  alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start_s),
    .src_a   (src_1),
    .src_b   (src_2),
    .done    (mul_done_s),
    .product (mul_prod_s)
  );
`endif

  // Control FSM next-state and output register loads.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    flags_d  = flags_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
`ifdef ALU_SEQ_MUL_EN
          if (op_s == OP_MUL) begin
            state_d = BUSY;
          end else begin
            state_d  = DONE;
            result_d = alu_res_s;
            flags_d  = alu_flags_s;
          end
`else
          state_d  = DONE;
          result_d = alu_res_s;
          flags_d  = alu_flags_s;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
`ifdef ALU_SEQ_MUL_EN
        if (mul_done_s) begin
          state_d          = DONE;
          result_d         = mul_prod_s[WIDTH-1:0];
          flags_d          = '0;
          flags_d.zero     = (mul_prod_s[WIDTH-1:0] == '0);
          flags_d.carry    = |mul_prod_s[2*WIDTH-1:WIDTH];
          flags_d.negative = mul_prod_s[WIDTH-1];
        end else begin
          state_d = BUSY;
        end
`else
        state_d = IDLE;
`endif
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // State, result and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      result_q    <= '0;
      flags_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = flags_q.zero;
  assign carry     = flags_q.carry;
  assign negative  = flags_q.negative;
  assign overflow  = flags_q.overflow;
  assign illegal   = flags_q.illegal;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq (WIDTH=16).
// Observed vectors are packed as {result[15:0], zero, carry, negative, overflow, illegal}.
module tb_alu_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] src_1;
  logic [15:0] src_2;
  logic [3:0]  alu_control;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        zero, carry, negative, overflow, illegal;

  int tests_run;
  int tests_failed;

  alu_seq #(.WIDTH(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .src_1       (src_1),
    .src_2       (src_2),
    .alu_control (alu_control),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .zero        (zero),
    .carry       (carry),
    .negative    (negative),
    .overflow    (overflow),
    .illegal     (illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Issue one op from IDLE; lat counts edges from the accept edge until out_valid.
  task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        output int lat, output logic [20:0] obs);
    alu_control = op;
    src_1       = a;
    src_2       = b;
    in_valid    = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    obs = {result, zero, carry, negative, overflow, illegal};
  endtask

  task automatic drain;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    logic [22:0] obs;
    rst_n = 1'b0;
    #12;
    obs = {in_ready, out_valid, result, zero, carry, negative, overflow, illegal};
    tests_run++;
    if (obs !== {1'b1, 1'b0, 16'h0000, 5'b00000}) begin
      $display("FAIL reset: got %h want %h", obs, {1'b1, 1'b0, 16'h0000, 5'b00000});
      tests_failed++;
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_arith;
    logic [3:0]  op_t  [8] = '{4'h0, 4'h0, 4'h1, 4'h1, 4'hC, 4'hC, 4'h7, 4'h8};
    logic [15:0] a_t   [8] = '{16'hFFFF, 16'h7FFF, 16'h8000, 16'h0000, 16'h0005, 16'h0003, 16'h7FFF, 16'h0000};
    logic [15:0] b_t   [8] = '{16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0005, 16'h0005, 16'h1234, 16'h1234};
    logic [20:0] exp_t [8] = '{{16'h0000, 5'b11000}, {16'h8000, 5'b00110}, {16'h7FFF, 5'b00010},
                               {16'hFFFF, 5'b01100}, {16'h0000, 5'b10000}, {16'h0000, 5'b01000},
                               {16'h8000, 5'b00110}, {16'hFFFF, 5'b01100}};
    int lat;
    logic [20:0] obs;
    for (int i = 0; i < 8; i++) begin
      run_op(op_t[i], a_t[i], b_t[i], lat, obs);
      tests_run++;
      if (obs !== exp_t[i] || lat != 1) begin
        $display("FAIL arith[%0d]: got %h lat %0d want %h lat 1", i, obs, lat, exp_t[i]);
        tests_failed++;
      end
      drain();
    end
  endtask

  task automatic test_logic_shift;
    logic [3:0]  op_t  [12] = '{4'h5, 4'h6, 4'hB, 4'h2, 4'h4, 4'h4, 4'h4, 4'h3, 4'h3, 4'hA, 4'hA, 4'hA};
    logic [15:0] a_t   [12] = '{16'hF0F0, 16'hF0F0, 16'hAAAA, 16'h00FF, 16'hF000, 16'h8000, 16'h8000,
                                16'h0001, 16'h0003, 16'h8000, 16'h8000, 16'h4000};
    logic [15:0] b_t   [12] = '{16'h3C3C, 16'h0F0F, 16'hAAAA, 16'h0000, 16'h0004, 16'h000F, 16'h0100,
                                16'h0010, 16'h0004, 16'h0014, 16'h0003, 16'h0001};
    logic [20:0] exp_t [12] = '{{16'h3030, 5'b00000}, {16'hFFFF, 5'b00100}, {16'h0000, 5'b10000},
                                {16'hFF00, 5'b00100}, {16'h0F00, 5'b00000}, {16'h0001, 5'b00000},
                                {16'h0000, 5'b10000}, {16'h0000, 5'b10000}, {16'h0030, 5'b00000},
                                {16'hFFFF, 5'b00100}, {16'hF000, 5'b00100}, {16'h2000, 5'b00000}};
    int lat;
    logic [20:0] obs;
    for (int i = 0; i < 12; i++) begin
      run_op(op_t[i], a_t[i], b_t[i], lat, obs);
      tests_run++;
      if (obs !== exp_t[i] || lat != 1) begin
        $display("FAIL logic_shift[%0d]: got %h lat %0d want %h lat 1", i, obs, lat, exp_t[i]);
        tests_failed++;
      end
      drain();
    end
  endtask

  task automatic test_illegal;
    logic [3:0] op_t [3] = '{4'hD, 4'hE, 4'hF};
    int lat;
    logic [20:0] obs;
    for (int i = 0; i < 3; i++) begin
      run_op(op_t[i], 16'h1234, 16'h5678, lat, obs);
      tests_run++;
      if (obs !== {16'h0000, 5'b00001} || lat != 1) begin
        $display("FAIL illegal[%0d]: got %h lat %0d want %h lat 1", i, obs, lat, {16'h0000, 5'b00001});
        tests_failed++;
      end
      drain();
    end
  endtask

  task automatic test_mul;
    logic [15:0] a_t [3] = '{16'h0100, 16'h0003, 16'h0000};
    logic [15:0] b_t [3] = '{16'h0101, 16'h0005, 16'hBEEF};
`ifdef ALU_SEQ_MUL_EN
    logic [20:0] exp_t [3] = '{{16'h0100, 5'b01000}, {16'h000F, 5'b00000}, {16'h0000, 5'b10000}};
    int exp_lat = 17;
`else
    logic [20:0] exp_t [3] = '{{16'h0000, 5'b00001}, {16'h0000, 5'b00001}, {16'h0000, 5'b00001}};
    int exp_lat = 1;
`endif
    int lat;
    logic [20:0] obs;
    for (int i = 0; i < 3; i++) begin
      run_op(4'h9, a_t[i], b_t[i], lat, obs);
      tests_run++;
      if (obs !== exp_t[i] || lat != exp_lat) begin
        $display("FAIL mul[%0d]: got %h lat %0d want %h lat %0d", i, obs, lat, exp_t[i], exp_lat);
        tests_failed++;
      end
      drain();
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    int seen;
    logic [20:0] obs;
    logic [17:0] st;
    run_op(4'h0, 16'h0002, 16'h0003, lat, obs);
    // Hold the result while a competing op is offered every cycle.
    alu_control = 4'h1;
    src_1       = 16'hFFFF;
    src_2       = 16'h0001;
    in_valid    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      st = {in_ready, out_valid, result};
      tests_run++;
      if (st !== {1'b0, 1'b1, 16'h0005}) begin
        $display("FAIL backpressure[%0d]: got %h want %h", i, st, {1'b0, 1'b1, 16'h0005});
        tests_failed++;
      end
    end
    in_valid = 1'b0;
    drain();
    st = {in_ready, out_valid, result};
    tests_run++;
    if (st !== {1'b1, 1'b0, 16'h0005}) begin
      $display("FAIL drain: got %h want %h", st, {1'b1, 1'b0, 16'h0005});
      tests_failed++;
    end
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    tests_run++;
    if (seen != 0) begin
      $display("FAIL ignored_input: got %0d out_valid cycles want 0", seen);
      tests_failed++;
    end
  endtask

  task automatic test_reset_mid;
    int lat;
    int seen;
    logic [20:0] obs;
    logic [22:0] st;
    // Leave a nonzero result behind so the reset has something to clear.
    run_op(4'h0, 16'h1111, 16'h2222, lat, obs);
    drain();
`ifdef ALU_SEQ_MUL_EN
    alu_control = 4'h9;
    src_1       = 16'h0100;
    src_2       = 16'h0101;
    in_valid    = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) begin
      @(posedge clk); #1;
    end
`else
    run_op(4'h0, 16'h0001, 16'h0001, lat, obs);
`endif
    rst_n = 1'b0;
    #1;
    st = {in_ready, out_valid, result, zero, carry, negative, overflow, illegal};
    tests_run++;
    if (st !== {1'b1, 1'b0, 16'h0000, 5'b00000}) begin
      $display("FAIL reset_mid: got %h want %h", st, {1'b1, 1'b0, 16'h0000, 5'b00000});
      tests_failed++;
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    tests_run++;
    if (seen != 0 || in_ready !== 1'b1) begin
      $display("FAIL abort_output: got %0d out_valid cycles in_ready %b want 0 and 1", seen, in_ready);
      tests_failed++;
    end
    run_op(4'h0, 16'h0002, 16'h0003, lat, obs);
    tests_run++;
    if (obs !== {16'h0005, 5'b00000} || lat != 1) begin
      $display("FAIL post_reset_add: got %h lat %0d want %h lat 1", obs, lat, {16'h0005, 5'b00000});
      tests_failed++;
    end
    drain();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    in_valid     = 1'b0;
    out_ready    = 1'b0;
    src_1        = 16'h0000;
    src_2        = 16'h0000;
    alu_control  = 4'h0;
    rst_n        = 1'b1;
    #1;
    test_reset();
    test_arith();
    test_logic_shift();
    test_illegal();
    test_mul();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
